filter_arbiter: RTL and testbench
=================================

# filter_arbiter

Round-robin controller that shares one filter datapath (16-bit data/valid/parity in, same out, fixed latency, no backpressure) among NREQ requesters. Sequences filter reset at start-up, issues at most one granted word per cycle, tags every issued word and steers the filter result back to the originating requester. Sits between the requester-side stream ports and a single filter instance; the filter's clock is shared and its reset is driven by this block.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- LAT, 2, filter latency in cycles from registered f_x_valid to f_y_valid
- INIT_CYCLES, 2, cycles f_rst is held high after reset

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- enable  in  1  1 = grant requests; 0 = stop granting and drain
- req_data  in  NREQ*16  requester i data in bits [16i+15:16i]
- req_valid  in  NREQ  request valid per requester
- req_parity  in  NREQ  parity bit per requester, passed through unmodified
- req_ready  out  NREQ  one-hot-or-zero grant; transfer when valid&ready
- resp_data  out  16  filtered data, shared
- resp_parity  out  1  filtered parity, shared
- resp_valid  out  NREQ  one-hot-or-zero; result belongs to requester i
- f_rst  out  1  filter reset
- f_x_data / f_x_valid / f_x_parity  out  16/1/1  filter inputs (registered)
- f_y_data / f_y_valid / f_y_parity  in  16/1/1  filter outputs
- idle  out  1  INIT done, not granting, nothing in flight
- proto_err  out  1  sticky: f_y_valid without matching in-flight tag

## Operation
- States: INIT, RUN, DRAIN, IDLE. rst -> INIT.
- INIT: f_rst=1 for INIT_CYCLES cycles (counter), req_ready=0; then -> RUN if enable else IDLE.
- RUN: round-robin grant among req_valid starting at pointer ptr; grant combinational from req_valid and registered ptr. On transfer, ptr <= granted index+1 (mod NREQ). enable=0 -> DRAIN (no grant that cycle).
- DRAIN: req_ready=0; when in-flight count = 0 -> IDLE.
- IDLE: idle=1; enable=1 -> RUN.
- Issue stage: on transfer, f_x_data/f_x_parity <= granted word, f_x_valid <= 1; otherwise f_x_valid <= 0, data holds.
- Tag pipe: LAT-deep shift of {valid, id[clog2(NREQ)-1:0]} aligned with f_x_valid.
- Response: resp_data=f_y_data, resp_parity=f_y_parity (combinational); resp_valid[i]=f_y_valid & tag_out.valid & tag_out.id==i.
- f_y_valid with tag_out.valid=0 -> proto_err<=1 (sticky until rst), no resp_valid. tag_out.valid with f_y_valid=0 also sets proto_err.
- In-flight counter: +1 on issue, -1 on tag exit, both in same cycle -> unchanged; width clog2(LAT+2).
- No response backpressure: consumers must accept resp_valid every cycle.

## Timing
- Reset values: req_ready=0, resp_valid=0, f_rst=1, f_x_valid=0, f_x_data=0, f_x_parity=0, idle=0, proto_err=0, ptr=0, tags cleared, counter=0.
- Latency: transfer at edge N -> f_x_valid at N+1 -> resp_valid at N+1+LAT.
- Throughput: one word per cycle sustained; back-to-back grants allowed to same requester only if no other requester is valid.
- enable falls during a transfer cycle: that transfer completes (grant evaluated on same-cycle enable, so no grant if enable=0).
- ptr wrap: NREQ-1 -> 0.
- rst mid-operation: all in-flight tags dropped, returns to INIT; late filter outputs suppressed because f_rst is asserted.

## Structure
- Shared package: state enum (INIT/RUN/DRAIN/IDLE), tag struct {valid,id}, ID_W=clog2(NREQ) function.
- One sub-module: rr_arbiter (NREQ req in, ptr in, one-hot grant and encoded index out), combinational.
- Filter instance lives at the level above; this block only drives/monitors its ports.

## Test plan (bench attaches the team's filter, y = 4*x, LAT=2)
- Reset: rst 2 cycles -> f_rst high for INIT_CYCLES after rst release, req_ready=0, then RUN; all outputs at reset values.
- Single: req 0 sends 3 -> resp_valid=0001, resp_data=12, resp_parity=0, exactly 1+LAT cycles after transfer.
- Contention: all four valid with data 1,2,3,4 continuously -> grants 0,1,2,3,0…; responses 4,8,12,16 routed to matching resp_valid bit, in order.
- Drain: enable=0 with 3 words in flight -> no further req_ready, 3 responses delivered, idle=1 one cycle after last.
- Mid-op reset: rst while 2 words in flight -> no resp_valid afterwards, proto_err=0, INIT re-entered.
- Protocol error: force f_y_valid=1 with empty tag pipe -> proto_err=1 and stays until rst; resp_valid=0.

Source files
------------

// File: rtl/filter_arbiter_pkg.sv
// Shared types for the filter arbiter: controller states, the in-flight tag
// carried alongside each filter word, and the requester-id width helper.
package filter_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_RUN,
    ST_DRAIN,
    ST_IDLE
  } state_e;

  // Tag id is sized for the largest supported requester count (8).
  localparam int TAG_ID_W = 3;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  // Width of an encoded requester index; never less than one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/filter_arbiter_rr.sv
// Combinational round-robin picker: the first asserted request at or after
// ptr (wrapping) wins; grant is one-hot-or-zero, idx is its encoded index.
module rr_arbiter
  import filter_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int ID_W = id_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  int j;

  // Scan requesters in rotating order starting at ptr.
  always_comb begin
    // NOTE: every output gets a default before the scan so no path can hold
    // an old value, which would otherwise infer a latch.
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int off = 0; off < NREQ; off++) begin
      j = (int'(ptr) + off) % NREQ;
      if (!any && req[j]) begin
        grant[j] = 1'b1;
        idx      = ID_W'(j);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/filter_arbiter.sv
// Shares one fixed-latency filter among NREQ requesters: sequences filter
// reset, grants one word per cycle round-robin, tags each issued word and
// steers the filter result back to the requester that sent it.
module filter_arbiter
  import filter_arbiter_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int LAT         = 2,
  parameter int INIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [NREQ*16-1:0] req_data,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ-1:0]  req_parity,
  output logic [NREQ-1:0]  req_ready,
  output logic [15:0]      resp_data,
  output logic             resp_parity,
  output logic [NREQ-1:0]  resp_valid,
  output logic             f_rst,
  output logic [15:0]      f_x_data,
  output logic             f_x_valid,
  output logic             f_x_parity,
  input  logic [15:0]      f_y_data,
  input  logic             f_y_valid,
  input  logic             f_y_parity,
  output logic             idle,
  output logic             proto_err
);

  localparam int ID_W   = id_w(NREQ);
  localparam int CNT_W  = $clog2(LAT + 2);
  localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

  state_e            state, state_next;
  logic [INIT_W-1:0] init_cnt;
  logic              init_done;
  logic [ID_W-1:0]   ptr;
  logic [NREQ-1:0]   arb_grant;
  logic [ID_W-1:0]   arb_idx;
  logic              arb_any;
  logic              granting;
  logic              transfer;
  tag_t              tag_q [0:LAT];
  tag_t              tag_out;
  logic [CNT_W-1:0]  inflight, inflight_next;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // Grants are only offered in RUN and only while enable is high this cycle.
  assign granting  = (state == ST_RUN) && enable;
  assign req_ready = granting ? arb_grant : '0;
  assign transfer  = granting && arb_any;

  assign init_done = (init_cnt == INIT_W'(INIT_CYCLES - 1));
  assign tag_out   = tag_q[LAT];

  // Filter is held in reset during our own reset so late words are flushed.
  assign f_rst       = rst || (state == ST_INIT);
  assign idle        = (state == ST_IDLE);
  assign resp_data   = f_y_data;
  assign resp_parity = f_y_parity;

  // In-flight count after this cycle's issue and tag exit.
  always_comb begin
    inflight_next = inflight;
    case ({transfer, tag_out.valid})
      2'b10:   inflight_next = inflight + 1'b1;
      2'b01:   inflight_next = inflight - 1'b1;
      default: inflight_next = inflight;
    endcase
  end

  // Next-state logic; DRAIN leaves as soon as the last tag exits.
  always_comb begin
    state_next = state;
    case (state)
      ST_INIT:  if (init_done) state_next = enable ? ST_RUN : ST_IDLE;
      ST_RUN:   if (!enable) state_next = ST_DRAIN;
      ST_DRAIN: if (inflight_next == '0) state_next = ST_IDLE;
      ST_IDLE:  if (enable) state_next = ST_RUN;
      default:  state_next = ST_INIT;
    endcase
  end

  // State register and INIT hold counter.
  always_ff @(posedge clk) begin
    // NOTE: state elements use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == ST_INIT && !init_done) init_cnt <= init_cnt + 1'b1;
    end
  end

  // Round-robin pointer: one past the last granted requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (transfer) begin
      ptr <= (arb_idx == ID_W'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
    end
  end

  // Issue stage: register the granted word toward the filter.
  always_ff @(posedge clk) begin
    if (rst) begin
      f_x_valid  <= 1'b0;
      f_x_data   <= '0;
      f_x_parity <= 1'b0;
    end else begin
      f_x_valid <= transfer;
      if (transfer) begin
        f_x_data   <= req_data[arb_idx*16 +: 16];
        f_x_parity <= req_parity[arb_idx];
      end
    end
  end

  // Tag pipe: stage 0 lines up with f_x_valid, stage LAT with f_y_valid.
  always_ff @(posedge clk) begin
    // NOTE: this shift register is reset, unlike a data memory, because a
    // stale valid bit would be mistaken for an in-flight word after reset.
    if (rst) begin
      for (int k = 0; k <= LAT; k++) tag_q[k] <= '0;
    end else begin
      tag_q[0] <= '{valid: transfer, id: TAG_ID_W'(arb_idx)};
      for (int k = 1; k <= LAT; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  // In-flight counter and sticky tag/filter mismatch flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight  <= '0;
      proto_err <= 1'b0;
    end else begin
      inflight <= inflight_next;
      if (f_y_valid != tag_out.valid) proto_err <= 1'b1;
    end
  end

  // Route the filter result to the requester named by the exiting tag.
  always_comb begin
    resp_valid = '0;
    if (f_y_valid && tag_out.valid) begin
      for (int i = 0; i < NREQ; i++) begin
        resp_valid[i] = (tag_out.id == TAG_ID_W'(i));
      end
    end
  end

endmodule

// File: tb/tb_filter_arbiter.sv
// Directed bench for filter_arbiter with a y = 4*x, two-cycle filter model.
module tb_filter_arbiter;

  localparam int NREQ        = 4;
  localparam int LAT         = 2;
  localparam int INIT_CYCLES = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable;
  logic [NREQ*16-1:0] req_data;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_parity;
  logic [NREQ-1:0]    req_ready;
  logic [15:0]        resp_data;
  logic               resp_parity;
  logic [NREQ-1:0]    resp_valid;
  logic               f_rst;
  logic [15:0]        f_x_data;
  logic               f_x_valid;
  logic               f_x_parity;
  logic [15:0]        f_y_data;
  logic               f_y_valid;
  logic               f_y_parity;
  logic               idle;
  logic               proto_err;

  logic        force_yv = 1'b0;
  logic        drop_yv  = 1'b0;
  logic        s1_v, y_v;
  logic [15:0] s1_d, y_d;
  logic        s1_p, y_p;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  filter_arbiter #(.NREQ(NREQ), .LAT(LAT), .INIT_CYCLES(INIT_CYCLES)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .req_data    (req_data),
    .req_valid   (req_valid),
    .req_parity  (req_parity),
    .req_ready   (req_ready),
    .resp_data   (resp_data),
    .resp_parity (resp_parity),
    .resp_valid  (resp_valid),
    .f_rst       (f_rst),
    .f_x_data    (f_x_data),
    .f_x_valid   (f_x_valid),
    .f_x_parity  (f_x_parity),
    .f_y_data    (f_y_data),
    .f_y_valid   (f_y_valid),
    .f_y_parity  (f_y_parity),
    .idle        (idle),
    .proto_err   (proto_err)
  );

  // Filter model: y = 4*x, parity passed through, two-stage, reset by f_rst.
  always @(posedge clk) begin
    if (f_rst) begin
      s1_v <= 1'b0; s1_d <= '0; s1_p <= 1'b0;
      y_v  <= 1'b0; y_d  <= '0; y_p  <= 1'b0;
    end else begin
      s1_v <= f_x_valid; s1_d <= {f_x_data[13:0], 2'b00}; s1_p <= f_x_parity;
      y_v  <= s1_v;      y_d  <= s1_d;                    y_p  <= s1_p;
    end
  end

  assign f_y_valid  = (y_v | force_yv) & ~drop_yv;
  assign f_y_data   = y_d;
  assign f_y_parity = y_p;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_resp(input string tag, input logic [3:0] v, input logic [15:0] d,
                            input logic p);
    check({tag, "_valid"}, resp_valid, v);
    if (v != 4'b0000) begin
      check({tag, "_data"}, resp_data, d);
      check({tag, "_parity"}, resp_parity, p);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_word(input int i, input logic [15:0] d, input logic p);
    req_data[i*16 +: 16] = d;
    req_parity[i]        = p;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; req_valid = '0; req_data = '0; req_parity = '0;
    step(); step();

    // Reset values while rst is held
    check("rst_f_rst", f_rst, 1);
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_f_x_valid", f_x_valid, 0);
    check("rst_f_x_data", f_x_data, 0);
    check("rst_f_x_parity", f_x_parity, 0);
    check("rst_idle", idle, 0);
    check("rst_proto_err", proto_err, 0);

    // INIT: filter reset for INIT_CYCLES, no grants even with requests
    rst = 1'b0; enable = 1'b1; req_valid = 4'b1111; settle();
    check("init0_f_rst", f_rst, 1);
    check("init0_ready", req_ready, 0);
    step();
    check("init1_f_rst", f_rst, 1);
    check("init1_ready", req_ready, 0);
    step();
    req_valid = '0; settle();
    check("run_f_rst", f_rst, 0);
    check("run_idle", idle, 0);

    // Single word from requester 0
    set_word(0, 16'd3, 1'b0); req_valid = 4'b0001; settle();
    check("single_ready", req_ready, 4'b0001);
    step();
    req_valid = '0; settle();
    check("single_fx_valid", f_x_valid, 1);
    check("single_fx_data", f_x_data, 3);
    check_resp("single_early0", 4'b0000, 0, 0);
    step();
    check_resp("single_early1", 4'b0000, 0, 0);
    step();
    check_resp("single", 4'b0001, 16'd12, 1'b0);

    // Only requester 3 valid with ptr at 1: grant 3, ptr wraps to 0
    set_word(3, 16'd5, 1'b1); req_valid = 4'b1000; settle();
    check("wrap_ready", req_ready, 4'b1000);
    step();
    req_valid = '0; step(); step();
    check_resp("wrap", 4'b1000, 16'd20, 1'b1);
    step();
    check_resp("wrap_after", 4'b0000, 0, 0);

    // Contention: all four valid for 8 cycles
    set_word(0, 16'd1, 1'b1); set_word(1, 16'd2, 1'b0);
    set_word(2, 16'd3, 1'b1); set_word(3, 16'd4, 1'b0);
    for (int k = 0; k < 11; k++) begin
      req_valid = (k < 8) ? 4'b1111 : 4'b0000; settle();
      if (k < 8) check($sformatf("cont_ready%0d", k), req_ready, 4'b0001 << (k % 4));
      if (k >= 3) begin
        int g;
        g = (k - 3) % 4;
        check_resp($sformatf("cont_resp%0d", k), 4'b0001 << g, 16'(4 * (g + 1)), (g % 2) == 0);
      end else begin
        check_resp($sformatf("cont_resp%0d", k), 4'b0000, 0, 0);
      end
      step();
    end
    check_resp("cont_after", 4'b0000, 0, 0);

    // Drain: three words in flight, then enable drops
    for (int d = 0; d < 7; d++) begin
      enable = (d < 3); req_valid = 4'b1111; settle();
      check($sformatf("drain_ready%0d", d), req_ready, (d < 3) ? (4'b0001 << d) : 4'b0000);
      if (d >= 3 && d <= 5) begin
        check_resp($sformatf("drain_resp%0d", d), 4'b0001 << (d - 3), 16'(4 * (d - 2)),
                   ((d - 3) % 2) == 0);
      end else begin
        check_resp($sformatf("drain_resp%0d", d), 4'b0000, 0, 0);
      end
      check($sformatf("drain_idle%0d", d), idle, d == 6);
      step();
    end

    // IDLE -> RUN, then back-to-back grants to the only valid requester
    enable = 1'b1; req_valid = '0; settle();
    check("idle_ready", req_ready, 0);
    check("idle_flag", idle, 1);
    step();
    set_word(0, 16'd7, 1'b0); req_valid = 4'b0001; settle();
    check("b2b_ready0", req_ready, 4'b0001);
    check("b2b_idle", idle, 0);
    step();
    check("b2b_ready1", req_ready, 4'b0001);
    step();

    // Mid-operation reset with two words in flight
    req_valid = '0; rst = 1'b1; settle();
    check("midrst_f_rst", f_rst, 1);
    for (int r = 0; r < 6; r++) begin
      step();
      if (r == 1) rst = 1'b0;
      settle();
      check_resp($sformatf("midrst_resp%0d", r), 4'b0000, 0, 0);
      check($sformatf("midrst_perr%0d", r), proto_err, 0);
      check($sformatf("midrst_f_rst%0d", r), f_rst, r <= 2);
    end

    // Protocol error: filter valid with an empty tag pipe
    force_yv = 1'b1; settle();
    check_resp("perr_resp", 4'b0000, 0, 0);
    step();
    force_yv = 1'b0; settle();
    check("perr_set", proto_err, 1);
    step(); step();
    check("perr_sticky", proto_err, 1);
    rst = 1'b1; step();
    rst = 1'b0; settle();
    check("perr_cleared", proto_err, 0);
    step(); step();

    // Protocol error: tag exits but filter result is missing
    set_word(1, 16'd2, 1'b0); req_valid = 4'b0010; settle();
    check("miss_ready", req_ready, 4'b0010);
    step();
    req_valid = '0; step(); step();
    drop_yv = 1'b1; settle();
    check_resp("miss_resp", 4'b0000, 0, 0);
    step();
    drop_yv = 1'b0; settle();
    check("miss_perr", proto_err, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
